// File: rtl/pipeline_retire_monitor_if.sv
// Retire-stage observation bundle: RW-stage inputs, trace drain handshake and status outputs.
interface pipeline_retire_monitor_if #(
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned CNT_W       = 32
);
    localparam int unsigned LVL_W = $clog2(TRACE_DEPTH) + 1;

    logic              RW_isWb;
    logic [3:0]        RW_rd;
    logic [31:0]       RW_Data_value;
    logic [31:0]       input_RW_PC;
    logic              isDataInterLock;
    logic              is_Branch_Taken;
    logic              isLastInstruction;
    logic              trace_valid;
    logic              trace_ready;
    logic [67:0]       trace_data;
    logic [LVL_W-1:0]  trace_level;
    logic              trace_overflow;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  wb_count;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;
    logic [1:0]        state;
    logic              done;
    logic              timeout;

    modport master (
        output RW_isWb, RW_rd, RW_Data_value, input_RW_PC, isDataInterLock,
               is_Branch_Taken, isLastInstruction, trace_ready,
        input  trace_valid, trace_data, trace_level, trace_overflow, cycle_count,
               wb_count, stall_count, flush_count, state, done, timeout
    );

    modport slave (
        input  RW_isWb, RW_rd, RW_Data_value, input_RW_PC, isDataInterLock,
               is_Branch_Taken, isLastInstruction, trace_ready,
        output trace_valid, trace_data, trace_level, trace_overflow, cycle_count,
               wb_count, stall_count, flush_count, state, done, timeout
    );
endinterface

// File: rtl/pipeline_retire_monitor.sv
// Retire monitor: saturating perf counters, writeback trace FIFO and a run/drain/done/timeout FSM
// that gives the host a hardware completion flag.
//
// state    | meaning
// ST_RUN   | observing the pipeline, idle timer armed
// ST_DRAIN | last instruction seen, counting out DRAIN_CYCLES more active cycles
// ST_DONE  | run finished normally; counters frozen, trace FIFO still drains
// ST_TIMEOUT | no writeback for TIMEOUT_CYCLES RUN cycles; frozen like DONE
module pipeline_retire_monitor #(
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_retire_monitor_if.slave mon
);
    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [LVL_W-1:0] FULL_LVL    = LVL_W'(TRACE_DEPTH);
    localparam logic [DRN_W-1:0] DRAIN_LOAD  = DRN_W'(DRAIN_CYCLES);
    localparam logic [31:0]      TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [31:0]       idle_q, idle_d;

    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  wb_q, wb_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic [67:0]       mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;

    logic              active;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        idle_d  = idle_q;
        unique case (state_q)
            ST_RUN: begin
                // Last instruction takes priority over a timeout on the same edge.
                if (mon.isLastInstruction) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                    idle_d  = '0;
                end else if (mon.RW_isWb) begin
                    idle_d = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    idle_d = idle_q + 32'd1;
                    if (idle_d == TIMEOUT_LIM) begin
                        state_d = ST_TIMEOUT;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - DRN_W'(1);
                if (drain_q == DRN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        cycle_d = cycle_q;
        wb_d    = wb_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (active) begin
            cycle_d = sat_inc(cycle_q, 1'b1);
            wb_d    = sat_inc(wb_q, mon.RW_isWb);
            stall_d = sat_inc(stall_q, mon.isDataInterLock);
            flush_d = sat_inc(flush_q, mon.is_Branch_Taken);
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push  = active && mon.RW_isWb;
    assign pop   = (level_q != '0) && mon.trace_ready;
    assign full  = (level_q == FULL_LVL);
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (push && full && !pop);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            idle_q   <= '0;
            cycle_q  <= '0;
            wb_q     <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            idle_q   <= idle_d;
            cycle_q  <= cycle_d;
            wb_q     <= wb_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {mon.input_RW_PC, mon.RW_rd, mon.RW_Data_value};
        end
    end

    // Head is masked while empty so the data output is zero out of reset.
    assign mon.trace_valid    = (level_q != '0);
    assign mon.trace_data     = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign mon.trace_level    = level_q;
    assign mon.trace_overflow = ovf_q;
    assign mon.cycle_count    = cycle_q;
    assign mon.wb_count       = wb_q;
    assign mon.stall_count    = stall_q;
    assign mon.flush_count    = flush_q;
    assign mon.state          = state_q;
    assign mon.done           = (state_q == ST_DONE);
    assign mon.timeout        = (state_q == ST_TIMEOUT);
endmodule

// File: tb/tb_pipeline_retire_monitor.sv
// Bench for pipeline_retire_monitor: directed scenarios plus random traffic against a queue-based model.
module tb_pipeline_retire_monitor;
    localparam int D    = 16;
    localparam int CW   = 32;
    localparam int DRN  = 4;
    localparam int TO_A = 4096;
    localparam longint MAXC = (longint'(1) << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic isWb, stall, br, last, ready;
    logic [3:0]  rd;
    logic [31:0] data, pc;

    always #5 clk = ~clk;

    pipeline_retire_monitor_if #(.TRACE_DEPTH(D), .CNT_W(CW)) if_a ();
    pipeline_retire_monitor_if #(.TRACE_DEPTH(D), .CNT_W(CW)) if_b ();
    pipeline_retire_monitor_if #(.TRACE_DEPTH(D), .CNT_W(CW)) if_c ();

    assign if_a.RW_isWb = isWb;  assign if_b.RW_isWb = isWb;  assign if_c.RW_isWb = isWb;
    assign if_a.RW_rd = rd;      assign if_b.RW_rd = rd;      assign if_c.RW_rd = rd;
    assign if_a.RW_Data_value = data; assign if_b.RW_Data_value = data; assign if_c.RW_Data_value = data;
    assign if_a.input_RW_PC = pc; assign if_b.input_RW_PC = pc; assign if_c.input_RW_PC = pc;
    assign if_a.isDataInterLock = stall; assign if_b.isDataInterLock = stall; assign if_c.isDataInterLock = stall;
    assign if_a.is_Branch_Taken = br;    assign if_b.is_Branch_Taken = br;    assign if_c.is_Branch_Taken = br;
    assign if_a.isLastInstruction = last; assign if_b.isLastInstruction = last; assign if_c.isLastInstruction = last;
    assign if_a.trace_ready = ready; assign if_b.trace_ready = ready; assign if_c.trace_ready = ready;

    pipeline_retire_monitor #(.TRACE_DEPTH(D), .CNT_W(CW), .DRAIN_CYCLES(DRN), .TIMEOUT_CYCLES(TO_A))
        u_a (.clk(clk), .reset(rst), .mon(if_a));
    pipeline_retire_monitor #(.TRACE_DEPTH(D), .CNT_W(CW), .DRAIN_CYCLES(DRN), .TIMEOUT_CYCLES(8))
        u_b (.clk(clk), .reset(rst), .mon(if_b));
    pipeline_retire_monitor #(.TRACE_DEPTH(D), .CNT_W(CW), .DRAIN_CYCLES(DRN), .TIMEOUT_CYCLES(0))
        u_c (.clk(clk), .reset(rst), .mon(if_c));

    int tests = 0;
    int fails = 0;

    // Reference model for u_a: state values 0=RUN 1=DRAIN 2=DONE 3=TIMEOUT.
    logic [67:0] mq[$];
    logic [67:0] sent[$];
    logic [67:0] got[$];
    bit     m_ovf;
    longint m_cyc, m_wb, m_st, m_fl;
    int     m_state, m_drain, m_idle;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input logic en);
        return (en && v < MAXC) ? v + 1 : v;
    endfunction

    task automatic model_step();
        bit act, pop;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_cyc = 0; m_wb = 0; m_st = 0; m_fl = 0;
            m_state = 0; m_drain = 0; m_idle = 0;
            return;
        end
        act = (m_state == 0 || m_state == 1);
        pop = (mq.size() != 0) && ready;
        if (act) begin
            m_cyc = sat(m_cyc, 1'b1);
            m_wb  = sat(m_wb, isWb);
            m_st  = sat(m_st, stall);
            m_fl  = sat(m_fl, br);
        end
        if (pop) void'(mq.pop_front());
        if (act && isWb) begin
            if (mq.size() < D) mq.push_back({pc, rd, data});
            else m_ovf = 1;
        end
        if (m_state == 0) begin
            if (last) begin
                m_state = 1;
                m_drain = DRN;
            end else if (isWb) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle >= TO_A) m_state = 3;
            end
        end else if (m_state == 1) begin
            m_drain--;
            if (m_drain == 0) m_state = 2;
        end
    endtask

    task automatic check_a();
        chk("valid", 68'(if_a.trace_valid), 68'(mq.size() != 0));
        chk("level", 68'(if_a.trace_level), 68'(mq.size()));
        chk("data", if_a.trace_data, (mq.size() != 0) ? mq[0] : 68'd0);
        chk("overflow", 68'(if_a.trace_overflow), 68'(m_ovf));
        chk("cycle_count", 68'(if_a.cycle_count), 68'(m_cyc));
        chk("wb_count", 68'(if_a.wb_count), 68'(m_wb));
        chk("stall_count", 68'(if_a.stall_count), 68'(m_st));
        chk("flush_count", 68'(if_a.flush_count), 68'(m_fl));
        chk("state", 68'(if_a.state), 68'(m_state));
        chk("done", 68'(if_a.done), 68'(m_state == 2));
        chk("timeout", 68'(if_a.timeout), 68'(m_state == 3));
    endtask

    task automatic tick();
        if (if_a.trace_valid && ready) got.push_back(if_a.trace_data);
        @(posedge clk);
        model_step();
        #1;
        check_a();
    endtask

    task automatic drive(input bit wb, input bit st, input bit b, input bit lst, input bit rdy);
        isWb = wb; stall = st; br = b; last = lst; ready = rdy;
        pc = $urandom; rd = 4'($urandom); data = $urandom;
        if (wb && m_state < 2) sent.push_back({pc, rd, data});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        sent.delete();
        got.delete();
    endtask

    task automatic cmp_q(input string tag, input int n);
        chk({tag, "_count"}, 68'(got.size()), 68'(n));
        for (int i = 0; i < n && i < got.size() && i < sent.size(); i++)
            chk(tag, got[i], sent[i]);
    endtask

    function automatic logic [9:0] rand_mask(input int k);
        logic [9:0] m = '0;
        for (int t = 0; t < 1000 && $countones(m) < k; t++) m[$urandom_range(9, 0)] = 1'b1;
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wbm, stm, brm;
        int n;
        rst = 1'b1;
        m_state = 0;
        drive(0, 0, 0, 0, 0);

        // Reset state
        do_reset();
        chk("rst_state", 68'(if_a.state), 68'd0);
        chk("rst_level", 68'(if_a.trace_level), 68'd0);
        chk("rst_data", if_a.trace_data, 68'd0);

        // 1: ten active cycles with 3 wb, 2 stalls, 1 branch
        do_reset();
        wbm = rand_mask(3); stm = rand_mask(2); brm = rand_mask(1);
        for (int i = 0; i < 10; i++) begin
            drive(wbm[i], stm[i], brm[i], 0, 1);
            tick();
        end
        chk("t1_cycle", 68'(if_a.cycle_count), 68'd10);
        chk("t1_wb", 68'(if_a.wb_count), 68'd3);
        chk("t1_stall", 68'(if_a.stall_count), 68'd2);
        chk("t1_flush", 68'(if_a.flush_count), 68'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        cmp_q("t1_order", 3);

        // 2: overflow with consumer stalled, then drain
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
        end
        chk("t2_level", 68'(if_a.trace_level), 68'd16);
        chk("t2_ovf", 68'(if_a.trace_overflow), 68'd1);
        chk("t2_wb", 68'(if_a.wb_count), 68'd17);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        chk("t2_valid_after16", 68'(if_a.trace_valid), 68'd0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        cmp_q("t2_order", 16);

        // 3: full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 1);
            tick();
            chk("t3_level", 68'(if_a.trace_level), 68'd16);
            chk("t3_ovf", 68'(if_a.trace_overflow), 68'd0);
        end
        for (int i = 0; i < 22; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        cmp_q("t3_order", 22);

        // 4: last-instruction pulse, drain, done
        do_reset();
        n = $urandom_range(8, 3);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 0, 1);
            tick();
        end
        drive(1, 0, 0, 1, 1);
        tick();
        chk("t4_drain_k", 68'(if_a.state), 68'd1);
        for (int j = 1; j <= 3; j++) begin
            drive(1, 1'($urandom), 0, 1, 1);
            tick();
            chk("t4_drain", 68'(if_a.state), 68'd1);
            chk("t4_notdone", 68'(if_a.done), 68'd0);
        end
        drive(1, 0, 0, 1, 1);
        tick();
        chk("t4_done", 68'(if_a.done), 68'd1);
        chk("t4_state", 68'(if_a.state), 68'd2);
        chk("t4_cycle", 68'(if_a.cycle_count), 68'(n + 5));
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 1, 1);
            tick();
        end
        chk("t4_frozen", 68'(if_a.cycle_count), 68'(n + 5));
        chk("t4_notraced", 68'(if_a.trace_valid), 68'd0);

        // 6: reset mid-drain discards queued entries
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            tick();
        end
        chk("t6_pre_level", 68'(if_a.trace_level), 68'd5);
        chk("t6_pre_state", 68'(if_a.state), 68'd1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        chk("t6_level", 68'(if_a.trace_level), 68'd0);
        chk("t6_valid", 68'(if_a.trace_valid), 68'd0);
        chk("t6_cycle", 68'(if_a.cycle_count), 68'd0);
        chk("t6_wb", 68'(if_a.wb_count), 68'd0);
        chk("t6_stall", 68'(if_a.stall_count), 68'd0);
        chk("t6_flush", 68'(if_a.flush_count), 68'd0);
        chk("t6_state", 68'(if_a.state), 68'd0);
        chk("t6_done", 68'(if_a.done), 68'd0);

        // 5: timeout behaviour (u_b: 8 cycles, u_c: disabled)
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        chk("t5_b_before", 68'(if_b.timeout), 68'd0);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("t5_b_timeout", 68'(if_b.timeout), 68'd1);
        chk("t5_b_state", 68'(if_b.state), 68'd3);
        chk("t5_c_none", 68'(if_c.timeout), 68'd0);

        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(i == 7, 0, 0, 0, 1);
            tick();
        end
        chk("t5_wb7_no_to", 68'(if_b.timeout), 68'd0);
        for (int i = 9; i <= 14; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        chk("t5_idle7_run", 68'(if_b.state), 68'd0);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("t5_idle8_to", 68'(if_b.timeout), 68'd1);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 1, 1);
        tick();
        chk("t5_last_wins", 68'(if_b.state), 68'd1);

        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 0, 1);
            tick();
        end
        chk("t5_c_state", 68'(if_c.state), 68'd0);
        chk("t5_c_timeout", 68'(if_c.timeout), 68'd0);

        // Random traffic against the model, varying consumer pressure
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 100) % 2 == 0) ? 25 : 85;
            drive(1'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0,
                  ($urandom % 150) == 0, $urandom_range(99, 0) < rdy_pct);
            tick();
            if (m_state >= 2 && $urandom_range(9, 0) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
